// File: rtl/ex_muldiv.sv
// ex_muldiv: RV32M multiply/divide unit in EX; shift-add multiply, restoring divide, one bit per cycle.
// Latency: done at T+WIDTH+1 after accept, T+1 for divide-by-zero/overflow, T+2 for multiplies with MULDIV_FAST_MUL_EN.
// Backpressure: stall holds ID/EX and upstream while accepting or iterating; released in DONE so the result advances.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nx;
    logic [2:0]         op;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    // accept-side decode
    logic               sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic               div_zero, div_ovf, special, accept;
    logic [WIDTH-1:0]   special_res;

    // iteration datapath
    logic               is_mul, last;
    logic [2*WIDTH-1:0] mul_nx, div_nx, acc_nx, prod;
    logic [WIDTH:0]     r_sh, diff;
    logic [WIDTH-1:0]   quo, rem, res_nx;
`ifdef MULDIV_FAST_MUL_EN
    logic                 op_sa, op_sb;
    logic signed [2*WIDTH+1:0] fast_prod;
`else
    logic [WIDTH:0]     mul_sum;
`endif

    // Operand signedness, magnitudes and the two divide corner cases, decoded straight off the inputs
    always_comb begin
        sgn_a_in    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b_in    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg_a_in    = sgn_a_in && rs1_val[WIDTH-1];
        neg_b_in    = sgn_b_in && rs2_val[WIDTH-1];
        mag_a_in    = neg_a_in ? -rs1_val : rs1_val;
        mag_b_in    = neg_b_in ? -rs2_val : rs2_val;
        div_zero    = (rs2_val == '0);
        div_ovf     = !funct3[0] && (rs1_val == MIN_NEG) && (rs2_val == '1);
        special     = funct3[2] && (div_zero || div_ovf);
        special_res = funct3[1] ? (div_zero ? rs1_val : '0) : (div_zero ? '1 : MIN_NEG);
        accept      = (state == IDLE) && start && !flush;
    end

    // One multiply or divide step on the accumulator, plus sign fixup of the final value
    always_comb begin
        is_mul = !op[2];
`ifdef MULDIV_FAST_MUL_EN
        // accumulator holds the raw operands; product is formed in one cycle with no fixup
        op_sa     = (op == 3'b001) || (op == 3'b010);
        op_sb     = (op == 3'b001);
        fast_prod = $signed({op_sa && acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]})
                  * $signed({op_sb && acc[WIDTH-1], acc[WIDTH-1:0]});
        mul_nx    = fast_prod[2*WIDTH-1:0];
        last      = is_mul || (cnt == CW'(WIDTH-1));
`else
        // {partial product, remaining multiplier}: add multiplicand on LSB, shift right
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nx  = {mul_sum, acc[WIDTH-1:1]};
        last    = (cnt == CW'(WIDTH-1));
`endif
        // {remainder, dividend/quotient}: shift in next dividend bit, subtract divisor if it fits
        r_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff   = r_sh - {1'b0, opnd};
        div_nx = diff[WIDTH] ? {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        acc_nx = is_mul ? mul_nx : div_nx;

        prod = (neg_a ^ neg_b) ? -acc_nx : acc_nx;
        quo  = acc_nx[WIDTH-1:0];
        rem  = acc_nx[2*WIDTH-1:WIDTH];
        if (is_mul)
            res_nx = (op[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        else if (op[1])
            res_nx = neg_a ? -rem : rem;
        else
            res_nx = (neg_a ^ neg_b) ? -quo : quo;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic and status outputs
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = special ? DONE : BUSY;
            BUSY:    if (flush) state_nx = IDLE;
                     else if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        stall = !rst && (accept || (state == BUSY));
        busy  = (state == BUSY);
        done  = (state == DONE);
    end

    // Operand capture at accept, iteration while busy, result load on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            op     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            op  <= funct3;
            cnt <= '0;
`ifdef MULDIV_FAST_MUL_EN
            if (!funct3[2]) begin
                neg_a <= 1'b0;
                neg_b <= 1'b0;
                opnd  <= '0;
                acc   <= {rs1_val, rs2_val};
            end else begin
                neg_a <= neg_a_in;
                neg_b <= neg_b_in;
                opnd  <= mag_b_in;
                acc   <= {{WIDTH{1'b0}}, mag_a_in};
            end
`else
            neg_a <= neg_a_in;
            neg_b <= neg_b_in;
            opnd  <= funct3[2] ? mag_b_in : mag_a_in;
            acc   <= {{WIDTH{1'b0}}, funct3[2] ? mag_a_in : mag_b_in};
`endif
            if (special) result <= special_res;
        end else if ((state == BUSY) && !flush) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
            if (last) result <= res_nx;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed checks of ex_muldiv results, latency, stall/busy/done, flush and reset.
// Latency: multiplies expected at T+33 (T+2 with MULDIV_FAST_MUL_EN), divides T+33, divide corner cases T+1.
// Backpressure: stall expected high from accept until the cycle before done.
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic        flush;
    logic        stall, busy, done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Issue one op in the next cycle T (start for one cycle only, operands scrambled afterwards);
    // return the cycle offset of done, result during done, stall-high cycles before done, stall at done.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output int stall_cnt,
                         output logic stall_done);
        @(negedge clk);
        start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b;
        lat = -1; res = 'x; stall_cnt = 0; stall_done = 1'bx;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (done) begin
                lat = n; res = result; stall_done = stall;
                break;
            end
            if (stall) stall_cnt++;
            @(negedge clk);
            start = 1'b0; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; flush = 1'b0; funct3 = 3'b000; rs1_val = 7; rs2_val = 6;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_mul;
        int lat, sc; logic [31:0] r; logic sd;
        issue(3'b000, 32'd7, 32'd6, lat, r, sc, sd);
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mul_latency got=%0d want=%0d", lat, MUL_LAT); end
        checks++; if (r !== 32'd42) begin errors++; $display("FAIL mul_result got=%h want=%h", r, 32'd42); end
        checks++; if (sc !== MUL_LAT) begin errors++; $display("FAIL mul_stall_cycles got=%0d want=%0d", sc, MUL_LAT); end
        checks++; if (sd !== 1'b0) begin errors++; $display("FAIL mul_stall_at_done got=%b want=0", sd); end
    endtask

    task automatic test_mul_high;
        int lat, sc; logic [31:0] r; logic sd;
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, lat, r, sc, sd);
        checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL mulh_result got=%h want=40000000", r); end
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mulh_latency got=%0d want=%0d", lat, MUL_LAT); end
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, r, sc, sd);
        checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_result got=%h want=fffffffe", r); end
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mulhu_latency got=%0d want=%0d", lat, MUL_LAT); end
        issue(3'b010, 32'hFFFF_FFFF, 32'd2, lat, r, sc, sd);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_result got=%h want=ffffffff", r); end
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mulhsu_latency got=%0d want=%0d", lat, MUL_LAT); end
    endtask

    task automatic test_div;
        int lat, sc; logic [31:0] r; logic sd;
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, lat, r, sc, sd);
        checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_result got=%h want=fffffffd", r); end
        checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL div_neg_latency got=%0d want=%0d", lat, DIV_LAT); end
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, lat, r, sc, sd);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg_result got=%h want=ffffffff", r); end
        checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL rem_neg_latency got=%0d want=%0d", lat, DIV_LAT); end
        issue(3'b101, 32'd100, 32'd7, lat, r, sc, sd);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_result got=%h want=%h", r, 32'd14); end
        checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL divu_latency got=%0d want=%0d", lat, DIV_LAT); end
        issue(3'b111, 32'd100, 32'd7, lat, r, sc, sd);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_result got=%h want=%h", r, 32'd2); end
    endtask

    task automatic test_div_special;
        int lat, sc; logic [31:0] r; logic sd;
        issue(3'b101, 32'd5, 32'd0, lat, r, sc, sd);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_result got=%h want=ffffffff", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL divu_zero_latency got=%0d want=1", lat); end
        checks++; if (sc !== 1) begin errors++; $display("FAIL divu_zero_stall_cycles got=%0d want=1", sc); end
        issue(3'b111, 32'd5, 32'd0, lat, r, sc, sd);
        checks++; if (r !== 32'd5) begin errors++; $display("FAIL remu_zero_result got=%h want=5", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL remu_zero_latency got=%0d want=1", lat); end
        issue(3'b110, 32'hFFFF_FFF9, 32'd0, lat, r, sc, sd);
        checks++; if (r !== 32'hFFFF_FFF9) begin errors++; $display("FAIL rem_zero_result got=%h want=fffffff9", r); end
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, sc, sd);
        checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_result got=%h want=80000000", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL div_ovf_latency got=%0d want=1", lat); end
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, sc, sd);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL rem_ovf_result got=%h want=0", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL rem_ovf_latency got=%0d want=1", lat); end
    endtask

    task automatic test_flush;
        int lat, sc; logic [31:0] r; logic sd;
        logic [31:0] prev;
        @(negedge clk);
        prev = result;
        start = 1'b1; funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b want=0", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b want=0", stall); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done got=%b want=0", done); end
        checks++; if (result !== prev) begin errors++; $display("FAIL flush_result got=%h want=%h", result, prev); end
        issue(3'b000, 32'd3, 32'd5, lat, r, sc, sd);
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL flush_next_latency got=%0d want=%0d", lat, MUL_LAT); end
        checks++; if (r !== 32'd15) begin errors++; $display("FAIL flush_next_result got=%h want=%h", r, 32'd15); end
    endtask

    task automatic test_reset_mid_op;
        int pulses;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1_val = 32'd9; rs2_val = 32'd9;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b want=0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got=%h want=0", result); end
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); #1;
            if (done) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d want=0", pulses); end
    endtask

    task automatic test_back_to_back;
        int pulses;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1_val = 32'd7; rs2_val = 32'd6;
        pulses = 0;
        for (int n = 0; n < 3*MUL_LAT + 10; n++) begin
            #1;
            if (done) pulses++;
            @(negedge clk);
            if (n == 2*MUL_LAT + 1) start = 1'b0;
        end
        #1;
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_done_pulses got=%0d want=2", pulses); end
        checks++; if (result !== 32'd42) begin errors++; $display("FAIL b2b_result got=%h want=%h", result, 32'd42); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%b want=0", busy); end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_mul_high;
        test_div;
        test_div_special;
        test_flush;
        test_reset_mid_op;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
